// File: rtl/slave_pkg.sv
// slave_pkg: shared FSM state type and packet layout for the slave endpoint
package slave_pkg;
  localparam int PKT_ADDR_W = 3;
  localparam int DEPTH = 2 ** PKT_ADDR_W;
  localparam int VAL_LSB = 0;
  localparam int ADDR_LSB = 3;
  localparam int SEL_BIT = 6;
  typedef enum logic [1:0] {IDLE, WAIT, READY, DONE} slave_state_e;
endpackage

// File: rtl/slave_regfile.sv
// slave_regfile: register array with async clear, one write port, registered read-before-write port
module slave_regfile import slave_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int RF_DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [RF_DEPTH];
  logic [DATA_W-1:0] mem_d [RF_DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // next array contents and read data; read sees the pre-write contents
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    rdata_d = mem_q[raddr];
  end
  // storage and read register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q <= mem_d;
      rdata_q <= rdata_d;
    end
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/slave_node.sv
// slave_node: slave endpoint with programmable ready latency, register file and saturating write counter
module slave_node import slave_pkg::*; #(
  parameter int WAIT_CYC = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] value_in,
  output logic              ready,
  output logic              handshake,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  wr_count
);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
  slave_state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, hs_q, hs_d, busy_q, busy_d;
  logic we;
  // next-state logic; outputs are decoded from the next state so they leave flops
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    we = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        state_d = (WAIT_CYC == 0) ? READY : WAIT;
        wcnt_d = WAIT_LD;
      end
      WAIT: if (!valid) state_d = IDLE;
        else if (wcnt_q == '0) state_d = READY;
        else wcnt_d = wcnt_q - 1'b1;
      READY: begin
        we = valid;
        state_d = valid ? DONE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (we && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    ready_d = state_d == READY;
    hs_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  // state, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      hs_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      hs_q <= hs_d;
      busy_q <= busy_d;
    end
  end
  slave_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(addr_in),
    .wdata(value_in),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  assign ready = ready_q;
  assign handshake = hs_q;
  assign busy = busy_q;
  assign wr_count = cnt_q;
endmodule

// File: tb/tb_slave_node.sv
// tb_slave_node: random and directed checks of two slave_node instances (WAIT_CYC=2 and 0) against a streak-count model
module tb_slave_node;
  logic clk, rst;
  logic v [2];
  logic [2:0] a [2], d [2], ra [2], rd [2];
  logic rdy [2], hs [2], bsy [2];
  logic [7:0] wc [2];
  int W [2] = '{2, 0};
  int streak [2], cool [2], cnt [2];
  logic [2:0] mem [2][8];
  logic [2:0] exp_rd [2];
  int checks = 0, errors = 0;

  slave_node #(.WAIT_CYC(2)) u0 (.clk(clk), .rst(rst), .valid(v[0]), .addr_in(a[0]), .value_in(d[0]),
    .ready(rdy[0]), .handshake(hs[0]), .busy(bsy[0]), .rd_addr(ra[0]), .rd_data(rd[0]), .wr_count(wc[0]));
  slave_node #(.WAIT_CYC(0)) u1 (.clk(clk), .rst(rst), .valid(v[1]), .addr_in(a[1]), .value_in(d[1]),
    .ready(rdy[1]), .handshake(hs[1]), .busy(bsy[1]), .rd_addr(ra[1]), .rd_data(rd[1]), .wr_count(wc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      streak[i] = 0;
      cool[i] = 0;
      cnt[i] = 0;
      exp_rd[i] = '0;
      for (int j = 0; j < 8; j++) mem[i][j] = '0;
    end
  endtask

  // a request is accepted on the (W+2)th consecutive high-valid edge; the edge after is ignored
  task automatic model_edge(input int i);
    exp_rd[i] = mem[i][ra[i]];
    if (cool[i] != 0) cool[i] = 0;
    else if (v[i]) begin
      streak[i]++;
      if (streak[i] == W[i] + 2) begin
        mem[i][a[i]] = d[i];
        cnt[i] = (cnt[i] == 255) ? 255 : cnt[i] + 1;
        streak[i] = 0;
        cool[i] = 1;
      end
    end else streak[i] = 0;
  endtask

  task automatic compare(input int i);
    chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(streak[i] == W[i] + 1));
    chk($sformatf("handshake%0d", i), 32'(hs[i]), 32'(cool[i]));
    chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(streak[i] > 0 || cool[i] != 0));
    chk($sformatf("rd_data%0d", i), 32'(rd[i]), 32'(exp_rd[i]));
    chk($sformatf("wr_count%0d", i), 32'(wc[i]), 32'(cnt[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  task automatic until_hs(input int i, input string tag);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = cool[i] != 0;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0; ra[i] = '0;
    end
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    // long latency write held until handshake, then read back
    v[0] = 1'b1; a[0] = 3'd5; d[0] = 3'd3;
    until_hs(0, "t1_hs");
    v[0] = 1'b0; ra[0] = 3'd5;
    tick();
    chk("t1_rd", 32'(rd[0]), 32'd3);
    chk("t1_cnt", 32'(wc[0]), 32'd1);
    // zero latency back-to-back with valid held high
    v[1] = 1'b1; a[1] = 3'd1; d[1] = 3'd7;
    until_hs(1, "t2_hs_a");
    a[1] = 3'd2; d[1] = 3'd4;
    until_hs(1, "t2_hs_b");
    v[1] = 1'b0; ra[1] = 3'd1;
    tick();
    ra[1] = 3'd2;
    chk("t2_rd1", 32'(rd[1]), 32'd7);
    tick();
    chk("t2_rd2", 32'(rd[1]), 32'd4);
    chk("t2_cnt", 32'(wc[1]), 32'd2);
    // request withdrawn during WAIT
    v[0] = 1'b1; a[0] = 3'd0; d[0] = 3'd6;
    tick();
    v[0] = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    chk("t3_cnt", 32'(wc[0]), 32'd1);
    // read-before-write on the same address
    ra[0] = 3'd6; v[0] = 1'b1; a[0] = 3'd6; d[0] = 3'd2;
    until_hs(0, "t4_hs");
    chk("t4_old", 32'(rd[0]), 32'd0);
    v[0] = 1'b0;
    tick();
    chk("t4_new", 32'(rd[0]), 32'd2);
    // async reset while ready
    v[0] = 1'b1; a[0] = 3'd3; d[0] = 3'd5; ra[0] = 3'd3;
    for (int n = 0; n < 10 && streak[0] != W[0] + 1; n++) tick();
    chk("t5_ready_pre", 32'(rdy[0]), 32'd1);
    #2 rst = 1'b1;
    #1 chk("t5_ready_async", 32'(rdy[0]), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    v[0] = 1'b0;
    tick();
    chk("t5_mem3", 32'(rd[0]), 32'd0);
    v[0] = 1'b1;
    until_hs(0, "t5_reaccept");
    v[0] = 1'b0;
    tick();
    chk("t5_rd", 32'(rd[0]), 32'd5);
    // random traffic on both instances
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || cool[i] != 0) begin
          a[i] = 3'($urandom);
          d[i] = 3'($urandom);
        end
        v[i] = $urandom_range(0, 9) != 0;
        ra[i] = 3'($urandom);
      end
      tick();
    end
    // counter saturation
    v[0] = 1'b0;
    v[1] = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (cool[1] != 0) begin
        a[1] = 3'($urandom);
        d[1] = 3'($urandom);
      end
      tick();
    end
    chk("sat_cnt", 32'(wc[1]), 32'd255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
